// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt engine: FSM state encoding,
// S-box depth and the printable-character window used for early key rejection.
package rc4_pkg;

    localparam int         S_DEPTH  = 256;
    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RD_SI,
        KSA_RD_SJ,
        KSA_WR_I,
        KSA_WR_J,
        PRGA_RD_SI,
        PRGA_RD_SJ,
        PRGA_WR_I,
        PRGA_WR_J,
        PRGA_RD_F,
        PRGA_WR_OUT,
        WAIT,
        DONE
    } rc4_state_e;

    // Accepts lowercase letters and space only; anything else marks the key as wrong.
    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Tracks i mod KEY_BYTES with a wrapping counter during the key schedule and
// presents the matching key byte (byte 0 is the most significant byte of key).
module rc4_key_byte_sel #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear_i,
    input  logic                   advance_i,
    input  logic [8*KEY_BYTES-1:0] key_i,
    output logic [7:0]             key_byte_o
);

    localparam int                IDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(KEY_BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       key_bytes [KEY_BYTES];

    for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key_bytes
        assign key_bytes[b] = key_i[8*(KEY_BYTES-b)-1 -: 8];
    end

    // NOTE: give every always_comb target a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (advance_i) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign key_byte_o = key_bytes[idx_q];

endmodule

// File: rtl/rc4_decrypt_engine.sv
// RC4 core: S-box init, key schedule and keystream decryption of one message
// against external S-memory, ciphertext ROM and plaintext RAM.
module rc4_decrypt_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES   = 3,
    parameter int MSG_LEN     = 32,
    parameter int MSG_AW      = 5,
    parameter int CHECK_ASCII = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic                   key_fail,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rdata,
    output logic [MSG_AW-1:0]      rom_addr,
    input  logic [7:0]             rom_rdata,
    output logic [MSG_AW-1:0]      out_addr,
    output logic [7:0]             out_wdata,
    output logic                   out_wren
);

    localparam logic [7:0]        I_LAST = 8'(S_DEPTH - 1);
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    rc4_state_e state_q, state_d;
    rc4_state_e ret_q, ret_d;

    logic [7:0]             i_q, i_d;
    logic [7:0]             j_q, j_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [7:0]             f_q, f_d;
    logic [7:0]             ct_q, ct_d;
    logic [MSG_AW-1:0]      k_q, k_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic                   key_fail_q, key_fail_d;

    logic       ks_clear;
    logic       ks_advance;
    logic [7:0] key_byte;
    logic [7:0] plain;
    logic [7:0] wait_addr;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (ks_clear),
        .advance_i  (ks_advance),
        .key_i      (key_q),
        .key_byte_o (key_byte)
    );

    assign plain = f_q ^ ct_q;

    // WAIT keeps driving the address of the read it follows, so the memory sees
    // a stable address for the whole read latency.
    always_comb begin
        wait_addr = 8'h00;
        case (ret_q)
            KSA_RD_SI, PRGA_RD_SI: wait_addr = i_q;
            KSA_RD_SJ, PRGA_RD_SJ: wait_addr = j_q;
            PRGA_RD_F:             wait_addr = si_q + sj_q;
            default:               wait_addr = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        f_d        = f_q;
        ct_d       = ct_q;
        k_d        = k_q;
        key_d      = key_q;
        key_fail_d = key_fail_q;
        ks_clear   = 1'b0;
        ks_advance = 1'b0;
        s_addr     = 8'h00;
        s_wdata    = 8'h00;
        s_wren     = 1'b0;
        out_addr   = '0;
        out_wdata  = 8'h00;
        out_wren   = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d      = key;
                    key_fail_d = 1'b0;
                    i_d        = 8'h00;
                    j_d        = 8'h00;
                    k_d        = '0;
                    ks_clear   = 1'b1;
                    state_d    = INIT;
                end
            end

            INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                if (i_q == I_LAST) begin
                    j_d     = 8'h00;
                    state_d = KSA_RD_SI;
                end
            end

            KSA_RD_SI: begin
                s_addr  = i_q;
                ret_d   = KSA_RD_SI;
                state_d = WAIT;
            end

            KSA_RD_SJ: begin
                s_addr  = j_q;
                ret_d   = KSA_RD_SJ;
                state_d = WAIT;
            end

            KSA_WR_I: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = KSA_WR_J;
            end

            KSA_WR_J: begin
                s_addr     = j_q;
                s_wdata    = si_q;
                s_wren     = 1'b1;
                i_d        = i_q + 8'd1;
                ks_advance = 1'b1;
                if (i_q == I_LAST) begin
                    j_d     = 8'h00;
                    k_d     = '0;
                    state_d = PRGA_RD_SI;
                end else begin
                    state_d = KSA_RD_SI;
                end
            end

            PRGA_RD_SI: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                ret_d   = PRGA_RD_SI;
                state_d = WAIT;
            end

            PRGA_RD_SJ: begin
                s_addr  = j_q;
                ret_d   = PRGA_RD_SJ;
                state_d = WAIT;
            end

            PRGA_WR_I: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = PRGA_WR_J;
            end

            PRGA_WR_J: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = PRGA_RD_F;
            end

            PRGA_RD_F: begin
                s_addr  = si_q + sj_q;
                ret_d   = PRGA_RD_F;
                state_d = WAIT;
            end

            PRGA_WR_OUT: begin
                out_addr  = k_q;
                out_wdata = plain;
                out_wren  = 1'b1;
                if ((CHECK_ASCII != 0) && !is_printable(plain)) begin
                    key_fail_d = 1'b1;
                    state_d    = DONE;
                end else if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = PRGA_RD_SI;
                end
            end

            WAIT: begin
                s_addr = wait_addr;
                case (ret_q)
                    KSA_RD_SI: begin
                        si_d    = s_rdata;
                        j_d     = j_q + s_rdata + key_byte;
                        state_d = KSA_RD_SJ;
                    end
                    KSA_RD_SJ: begin
                        sj_d    = s_rdata;
                        state_d = KSA_WR_I;
                    end
                    PRGA_RD_SI: begin
                        si_d    = s_rdata;
                        j_d     = j_q + s_rdata;
                        state_d = PRGA_RD_SJ;
                    end
                    PRGA_RD_SJ: begin
                        sj_d    = s_rdata;
                        state_d = PRGA_WR_I;
                    end
                    PRGA_RD_F: begin
                        f_d     = s_rdata;
                        ct_d    = rom_rdata;
                        state_d = PRGA_WR_OUT;
                    end
                    default: state_d = IDLE;
                endcase
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            i_q        <= 8'h00;
            j_q        <= 8'h00;
            si_q       <= 8'h00;
            sj_q       <= 8'h00;
            f_q        <= 8'h00;
            ct_q       <= 8'h00;
            k_q        <= '0;
            key_q      <= '0;
            key_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            ct_q       <= ct_d;
            k_q        <= k_d;
            key_q      <= key_d;
            key_fail_q <= key_fail_d;
        end
    end

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign key_fail = key_fail_q;
    assign rom_addr = k_q;

endmodule
